// File: rtl/ser_pkg.sv
// Framing definitions shared by the serializer and the deframer so both ends agree on line levels and states.
package ser_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ser_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/ser_out_buf.sv
// One-entry valid/ready holding register for received words; flags an overrun when a
// good word arrives while the held word is neither empty nor being drained.
module ser_out_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  overrun_o
);
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (load_i) begin
        // A word leaving this cycle frees the slot for the arriving one.
        if (!valid_q || ready_i) begin
          data_q  <= word_i;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
endmodule

// File: rtl/ser_deframer.sv
// Serial receive deframer: start bit, DATA_WIDTH data bits LSB-first, optional even parity, stop bit.
// Define SER_DEFRAMER_PARITY_EN to expect a parity bit between the data and stop bits.
module ser_deframer
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  overrun
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  ser_state_e            state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  frame_err_q;
  logic                  stop_ok;
  logic                  load;
`ifdef SER_DEFRAMER_PARITY_EN
  logic                  par_q;

  always_comb begin
    stop_ok = (ser_in == STOP_BIT) && ((^shift_q ^ par_q) == 1'b0);
  end
`else
  always_comb begin
    stop_ok = (ser_in == STOP_BIT);
  end
`endif

  assign load = (state_q == STOP) && stop_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frame_err_q <= 1'b0;
`ifdef SER_DEFRAMER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ser_in == START_BIT) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          shift_q   <= (shift_q & ~(DATA_WIDTH'(1) << bit_cnt_q))
                     | (DATA_WIDTH'(ser_in) << bit_cnt_q);
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SER_DEFRAMER_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= STOP;
`endif
          end
        end
`ifdef SER_DEFRAMER_PARITY_EN
        PARITY: begin
          par_q   <= ser_in;
          state_q <= STOP;
        end
`endif
        STOP: begin
          // Bad frames report here and never reach the output buffer.
          frame_err_q <= !stop_ok;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;

  ser_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .word_i   (shift_q),
    .ready_i  (data_ready),
    .data_o   (data_out),
    .valid_o  (data_valid),
    .overrun_o(overrun)
  );
endmodule

// File: tb/tb_ser_deframer.sv
// Directed bench for ser_deframer: table of frames plus hand-written latency, back-to-back,
// backpressure, reset and break sequences; parity cases when SER_DEFRAMER_PARITY_EN is defined.
module tb_ser_deframer;
  logic       clk;
  logic       rst;
  logic       ser_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  int xfer_cnt = 0;
  logic [7:0] last_xfer = '0;

`ifdef SER_DEFRAMER_PARITY_EN
  localparam int PERIOD = 11;
`else
  localparam int PERIOD = 10;
`endif

  ser_deframer #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_valid && data_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= data_out;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b);
    ser_in = b;
    @(posedge clk);
    #1;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
  endtask

  task automatic send_body(input logic [7:0] d, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SER_DEFRAMER_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b === 1'bx) ser_in = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_body(d, par_b);
    drive_bit(stop_b);
  endtask

  initial begin
    logic [7:0] exp_last;
    int base;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b1};

    rst = 1'b0;
    ser_in = 1'b1;
    data_ready = 1'b1;
    #12;
    chk("reset_valid", data_valid, 0);
    chk("reset_data", data_out, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_ovr", overrun, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) drive_bit(1'b1);

    // Latency: valid appears on the stop-sampling edge and clears after one transfer.
    send_body(8'hA5, ^8'hA5);
    chk("lat_pre_valid", data_valid, 0);
    drive_bit(1'b1);
    chk("lat_valid", data_valid, 1);
    chk("lat_data", data_out, 8'hA5);
    drive_bit(1'b1);
    chk("lat_clear", data_valid, 0);

    exp_last = 8'hA5;
    foreach (vecs[k]) begin
      ferr_cnt = 0;
      ovr_cnt = 0;
      send_frame(vecs[k].data, vecs[k].stop, ^vecs[k].data);
      if (vecs[k].exp_valid) exp_last = vecs[k].data;
      chk($sformatf("tbl%0d_valid", k), data_valid, vecs[k].exp_valid);
      chk($sformatf("tbl%0d_data", k), data_out, exp_last);
      chk($sformatf("tbl%0d_ferr", k), frame_err, vecs[k].exp_ferr);
      chk($sformatf("tbl%0d_ovr", k), overrun, 0);
      drive_bit(1'b1);
      chk($sformatf("tbl%0d_clear", k), data_valid, 0);
      chk($sformatf("tbl%0d_ferr_pulses", k), ferr_cnt, vecs[k].exp_ferr);
      chk($sformatf("tbl%0d_ovr_pulses", k), ovr_cnt, 0);
    end

    // Back-to-back frames with no idle gap.
    ferr_cnt = 0;
    ovr_cnt = 0;
    send_frame(8'h3C, 1'b1, ^8'h3C);
    chk("b2b_valid0", data_valid, 1);
    chk("b2b_data0", data_out, 8'h3C);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    chk("b2b_valid1", data_valid, 1);
    chk("b2b_data1", data_out, 8'hFF);
    drive_bit(1'b1);
    chk("b2b_ferr", ferr_cnt, 0);
    chk("b2b_ovr", ovr_cnt, 0);

    // Backpressure: second word dropped with a single overrun pulse.
    data_ready = 1'b0;
    ovr_cnt = 0;
    send_frame(8'h11, 1'b1, ^8'h11);
    chk("bp_valid", data_valid, 1);
    chk("bp_data", data_out, 8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    chk("bp_ovr_pulse", overrun, 1);
    chk("bp_data_hold", data_out, 8'h11);
    drive_bit(1'b1);
    chk("bp_ovr_end", overrun, 0);
    chk("bp_still_valid", data_valid, 1);
    base = xfer_cnt;
    data_ready = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("bp_drained", data_valid, 0);
    chk("bp_xfers", xfer_cnt - base, 1);
    chk("bp_xfer_word", last_xfer, 8'h11);
    chk("bp_ovr_count", ovr_cnt, 1);

    // Reset mid-frame with a held word present.
    data_ready = 1'b0;
    send_frame(8'h6E, 1'b1, ^8'h6E);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", data_valid, 0);
    chk("rst_mid_data", data_out, 0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    chk("rst_hold_all", {data_out, data_valid, frame_err, overrun}, 0);
    rst = 1'b1;
    data_ready = 1'b1;
    ferr_cnt = 0;
    ovr_cnt = 0;
    for (int i = 0; i < 12; i++) drive_bit(1'b1);
    chk("rst_post_valid", data_valid, 0);
    chk("rst_post_ferr", ferr_cnt, 0);
    chk("rst_post_ovr", ovr_cnt, 0);

    // Break: line held low yields one framing error per frame period.
    ferr_cnt = 0;
    for (int i = 0; i < 3 * PERIOD; i++) drive_bit(1'b0);
    chk("brk_ferr_pulses", ferr_cnt, 3);
    chk("brk_valid", data_valid, 0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h01, 1'b1, ^8'h01);
    chk("brk_recover_valid", data_valid, 1);
    chk("brk_recover_data", data_out, 8'h01);
    drive_bit(1'b1);

`ifdef SER_DEFRAMER_PARITY_EN
    ferr_cnt = 0;
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par_ok_valid", data_valid, 1);
    chk("par_ok_data", data_out, 8'h07);
    chk("par_ok_ferr", frame_err, 0);
    drive_bit(1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par_bad_valid", data_valid, 0);
    chk("par_bad_ferr", frame_err, 1);
    drive_bit(1'b1);
    chk("par_bad_pulses", ferr_cnt, 1);
`endif

    chk("never_both", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ser_deframer.md
Name: ser_deframer

Overview:
- Receive stage directly downstream of the serializer. Consumes its single-bit serial output, one bit per clk.
- Detects frame boundaries, reassembles the data word LSB-first and checks the stop bit (and optionally parity).
- Presents each good word on a one-entry valid/ready output buffer to the consuming logic.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; also the width of data_out.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset: asserted when low, released synchronously to clk by the system.
- ser_in  input  1  serial line. Idles high. Frame = start(0), DATA_WIDTH data bits LSB-first, [parity], stop(1).
- data_out  output  DATA_WIDTH  received word; held stable while data_valid=1 and data_ready=0.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts; a transfer happens on any clk edge where data_valid=1 and data_ready=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0, or parity mismatch when parity is enabled.
- overrun  output  1  one-cycle pulse: a good frame completed while the buffer was full and not being drained.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit_cnt=0, data_out=0, data_valid=0, frame_err=0, overrun=0.
- State machine. The stop bit is sampled in the cycle the FSM is in STOP.
  - IDLE: ser_in=1 keeps IDLE. ser_in=0 is taken as the start bit; go to DATA with bit_cnt=0.
  - DATA: each cycle shift ser_in into bit position bit_cnt (LSB first) and increment bit_cnt. After DATA_WIDTH bits go to PARITY if enabled, otherwise STOP. bit_cnt is $clog2(DATA_WIDTH+1) bits wide and never wraps within a frame.
  - PARITY (feature only): capture the received parity bit, then go to STOP.
  - STOP: ser_in=1 and no parity error means a good frame. Otherwise pulse frame_err on the next cycle and discard the word. Always return to IDLE.
- A start bit may arrive in the cycle immediately after STOP, so back-to-back frames must be accepted. Minimum frame period is DATA_WIDTH+2 cycles (+1 with parity).
- Latency: data_valid=1 and data_out updated on the clk edge that samples a good stop bit. Both are visible the cycle after STOP.
- Buffer update on a good frame:
  - buffer empty, or data_valid=1 and data_ready=1 in that cycle: load the new word; data_valid=1.
  - data_valid=1 and data_ready=0: keep the old word, drop the new one, pulse overrun for one cycle.
- A transfer with no frame completing clears data_valid on the next edge.
- A frame with a framing error never changes data_out or data_valid.
- ser_in=0 held continuously (break) produces frames of all-zero data with a stop error, i.e. a frame_err pulse every DATA_WIDTH+2 cycles. No lock-up.
- Reset mid-frame aborts the frame silently; no error pulse after reset release.
- frame_err and overrun are never both asserted in the same cycle.

Optional Feature:
- Macro: SER_DEFRAMER_PARITY_EN.
- With the macro defined: the PARITY state is present. One even-parity bit follows the data bits: the XOR of the data bits and the parity bit must be 0. A mismatch is reported as frame_err at stop and the word is discarded.
- Without the macro: no PARITY state; frame is start + data + stop; parity logic is absent.

Decomposition:
- Shared package ser_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP);
  - constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- The serializer uses the same package so framing stays consistent between the two blocks.
- One sub-module is natural: ser_out_buf, the one-entry valid/ready holding register that also produces overrun. The FSM and shifter stay in ser_deframer.

Test Plan:
- Reset: rst=0 mid-frame with ser_in toggling -> all outputs 0. After release, an idle-high line keeps data_valid=0 with no pulses.
- Single frame, DATA_WIDTH=8, data_ready=1: bits 0,1,0,1,0,0,1,0,1,1 -> data_out=8'hA5, data_valid=1 exactly one cycle after the stop bit, then cleared.
- Back-to-back: frames 8'h3C then 8'hFF with no idle gap, data_ready=1 -> two words in order, no frame_err, no overrun.
- Framing error: 8'h5A sent with stop=0 -> frame_err pulses once; data_valid stays 0. The next good frame 8'h01 is received correctly.
- Backpressure: data_ready=0, send 8'h11 then 8'h22 -> data_out=8'h11 held and overrun pulses once. After raising data_ready, one transfer of 8'h11 occurs.
- Parity (SER_DEFRAMER_PARITY_EN):
  - 8'h07 with parity bit 1 -> accepted;
  - 8'h07 with parity bit 0 -> frame_err, no data_valid.
